// File: rtl/x4xx_version_scanner.sv
// CtrlPort initiator that scans the versioning registers and checks SW compatibility.
// Optional LAST_MODIFIED read and storage: define VERSION_SCAN_TIMESTAMP_EN.
module x4xx_version_scanner #(
    parameter int REG_BASE       = 0,
    parameter int NUM_COMPONENTS = 6,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                          ctrlport_clk,
    input  logic                          ctrlport_rst,
    output logic                          m_ctrlport_req_wr,
    output logic                          m_ctrlport_req_rd,
    output logic [19:0]                   m_ctrlport_req_addr,
    output logic [31:0]                   m_ctrlport_req_data,
    input  logic                          m_ctrlport_resp_ack,
    input  logic [1:0]                    m_ctrlport_resp_status,
    input  logic [31:0]                   m_ctrlport_resp_data,
    input  logic                          start,
    input  logic [64*NUM_COMPONENTS-1:0]  sw_versions,
    output logic                          busy,
    output logic                          done,
    output logic [NUM_COMPONENTS-1:0]     incompat_mask,
    output logic [NUM_COMPONENTS-1:0]     error_mask,
    input  logic [5:0]                    rd_index,
    output logic [31:0]                   rd_current,
    output logic [31:0]                   rd_oldest,
    output logic [31:0]                   rd_timestamp,
    output logic [2:0]                    fsm_state
);

    localparam int IW = (NUM_COMPONENTS > 1) ? $clog2(NUM_COMPONENTS) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
`ifdef VERSION_SCAN_TIMESTAMP_EN
    localparam logic [1:0] LAST_OFF = 2'd2;
`else
    localparam logic [1:0] LAST_OFF = 2'd1;
`endif

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, GUARD, CHECK, NEXT, DONE} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   idx;
    logic [1:0]      off;
    logic [TW-1:0]   timer;
    logic [1:0]      guard_cnt;
    logic [31:0]     cur_mem [NUM_COMPONENTS];
    logic [31:0]     old_mem [NUM_COMPONENTS];
`ifdef VERSION_SCAN_TIMESTAMP_EN
    logic [31:0]     ts_mem  [NUM_COMPONENTS];
`endif
    logic [31:0]     sw_cur, sw_old;
    logic            last_idx, rd_valid;
    logic [IW-1:0]   rd_sel;

    // Handshake: req_rd is a one-cycle strobe qualified by req_addr; exactly one
    // request is outstanding and only an ack seen in WAIT_ACK completes it.
    assign m_ctrlport_req_wr   = 1'b0;
    assign m_ctrlport_req_data = '0;
    assign m_ctrlport_req_rd   = (state == ISSUE);
    assign m_ctrlport_req_addr = m_ctrlport_req_rd ?
        20'(REG_BASE) + (20'(idx) << 4) + 20'({off, 2'b00}) : '0;
    assign busy      = (state != IDLE) && (state != DONE);
    assign done      = (state == DONE);
    assign fsm_state = state;
    assign sw_cur    = sw_versions[64*idx +: 32];
    assign sw_old    = sw_versions[64*idx+32 +: 32];
    assign last_idx  = (idx == IW'(NUM_COMPONENTS - 1));

    always_ff @(posedge ctrlport_clk or posedge ctrlport_rst) begin
        if (ctrlport_rst) state <= IDLE;
        else              state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start) state_nxt = ISSUE;
            ISSUE:    state_nxt = WAIT_ACK;
            WAIT_ACK: begin
                if (m_ctrlport_resp_ack) begin
                    if (m_ctrlport_resp_status != 2'd0) state_nxt = NEXT;
                    else if (off == LAST_OFF)           state_nxt = CHECK;
                    else                                state_nxt = ISSUE;
                end else if (timer == '0) begin
                    state_nxt = GUARD;
                end
            end
            GUARD:    if (guard_cnt == 2'd0) state_nxt = NEXT;
            CHECK:    state_nxt = NEXT;
            NEXT:     state_nxt = last_idx ? DONE : ISSUE;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ctrlport_clk or posedge ctrlport_rst) begin
        if (ctrlport_rst) begin
            idx           <= '0;
            off           <= '0;
            timer         <= '0;
            guard_cnt     <= '0;
            incompat_mask <= '0;
            error_mask    <= '0;
            for (int i = 0; i < NUM_COMPONENTS; i++) begin
                cur_mem[i] <= '0;
                old_mem[i] <= '0;
`ifdef VERSION_SCAN_TIMESTAMP_EN
                ts_mem[i]  <= '0;
`endif
            end
        end else begin
            case (state)
                IDLE: if (start) begin
                    idx           <= '0;
                    off           <= '0;
                    incompat_mask <= '0;
                    error_mask    <= '0;
                end
                ISSUE: timer <= TW'(TIMEOUT_CYCLES - 1);
                WAIT_ACK: begin
                    if (m_ctrlport_resp_ack && m_ctrlport_resp_status == 2'd0) begin
                        case (off)
                            2'd0:    cur_mem[idx] <= m_ctrlport_resp_data;
                            2'd1:    old_mem[idx] <= m_ctrlport_resp_data;
`ifdef VERSION_SCAN_TIMESTAMP_EN
                            2'd2:    ts_mem[idx]  <= m_ctrlport_resp_data;
`endif
                            default: ;
                        endcase
                        off <= off + 2'd1;
                    end else if (m_ctrlport_resp_ack || timer == '0) begin
                        // Failed component: drop partial data so readback shows 0.
                        error_mask[idx] <= 1'b1;
                        cur_mem[idx]    <= '0;
                        old_mem[idx]    <= '0;
`ifdef VERSION_SCAN_TIMESTAMP_EN
                        ts_mem[idx]     <= '0;
`endif
                        guard_cnt       <= 2'd3;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                GUARD: guard_cnt <= guard_cnt - 2'd1;
                CHECK: incompat_mask[idx] <= (sw_old > cur_mem[idx]) || (sw_cur < old_mem[idx]);
                NEXT: if (!last_idx) begin
                    idx <= idx + 1'b1;
                    off <= '0;
                end
                default: ;
            endcase
        end
    end

    assign rd_valid = ({1'b0, rd_index} < 7'(NUM_COMPONENTS));
    assign rd_sel   = rd_index[IW-1:0];

    always_comb begin
        rd_current   = '0;
        rd_oldest    = '0;
        rd_timestamp = '0;
        if (rd_valid) begin
            rd_current = cur_mem[rd_sel];
            rd_oldest  = old_mem[rd_sel];
`ifdef VERSION_SCAN_TIMESTAMP_EN
            rd_timestamp = ts_mem[rd_sel];
`endif
        end
    end

endmodule

// File: tb/tb_x4xx_version_scanner.sv
// Directed bench for x4xx_version_scanner: scripted CtrlPort responder, address scoreboard,
// mask/readback checks for OKAY, incompatible, error-status, timeout and mid-scan reset cases.
module tb_x4xx_version_scanner;

    localparam int NC       = 2;
    localparam int REG_BASE = 'h1000;
    localparam int TO       = 64;
`ifdef VERSION_SCAN_TIMESTAMP_EN
    localparam int NREADS = 3;
    localparam logic [31:0] EXP_TS = 32'h21061512;
`else
    localparam int NREADS = 2;
    localparam logic [31:0] EXP_TS = 32'h0;
`endif
    // ISSUE + TO wait cycles + 4 guard + NEXT
    localparam int TIMEOUT_GAP = 1 + TO + 4 + 1;

    logic          clk, rst;
    logic          req_wr, req_rd;
    logic [19:0]   req_addr;
    logic [31:0]   req_data;
    logic          resp_ack;
    logic [1:0]    resp_status;
    logic [31:0]   resp_data;
    logic          start;
    logic [64*NC-1:0] sw_versions;
    logic          busy, done;
    logic [NC-1:0] incompat_mask, error_mask;
    logic [5:0]    rd_index;
    logic [31:0]   rd_current, rd_oldest, rd_timestamp;
    logic [2:0]    fsm_state;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] cur_v[NC], old_v[NC], ts_v[NC];
    bit          noack_mode = 0, err_mode = 0, pend = 0;
    logic [31:0] pend_addr;
    int          since = 0, gap_comp1 = 0, n_strobes = 0;

    x4xx_version_scanner #(
        .REG_BASE(REG_BASE), .NUM_COMPONENTS(NC), .TIMEOUT_CYCLES(TO)
    ) dut (
        .ctrlport_clk(clk), .ctrlport_rst(rst),
        .m_ctrlport_req_wr(req_wr), .m_ctrlport_req_rd(req_rd),
        .m_ctrlport_req_addr(req_addr), .m_ctrlport_req_data(req_data),
        .m_ctrlport_resp_ack(resp_ack), .m_ctrlport_resp_status(resp_status),
        .m_ctrlport_resp_data(resp_data),
        .start(start), .sw_versions(sw_versions),
        .busy(busy), .done(done),
        .incompat_mask(incompat_mask), .error_mask(error_mask),
        .rd_index(rd_index), .rd_current(rd_current), .rd_oldest(rd_oldest),
        .rd_timestamp(rd_timestamp), .fsm_state(fsm_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_data(input logic [31:0] a);
        int c, o;
        c = int'((a - REG_BASE) >> 4);
        o = int'((a >> 2) & 3);
        if (c >= NC) return 32'h0;
        case (o)
            0:       return cur_v[c];
            1:       return old_v[c];
            2:       return ts_v[c];
            default: return 32'h0;
        endcase
    endfunction

    // Responder: acks one cycle after the strobe (first WAIT cycle), unless scripted otherwise.
    initial begin
        resp_ack = 0; resp_status = 0; resp_data = 0;
        forever begin
            @(negedge clk);
            resp_ack = 0; resp_status = 0; resp_data = 0;
            since++;
            if (rst) begin
                pend = 0;
            end else begin
                if (pend) begin
                    pend = 0;
                    if (!(noack_mode && pend_addr == REG_BASE)) begin
                        resp_ack    = 1;
                        resp_status = (err_mode && pend_addr == REG_BASE) ? 2'd1 : 2'd0;
                        resp_data   = model_data(pend_addr);
                    end
                end
                if (noack_mode && since == 66) begin
                    resp_ack  = 1;
                    resp_data = 32'hDEADBEEF;
                end
                if (req_rd) begin
                    if (req_addr == 20'(REG_BASE + 16)) gap_comp1 = since;
                    since = 0;
                    n_strobes++;
                    check_val("req_wr", {31'b0, req_wr}, 32'h0);
                    if (exp_q.size() == 0) check_val("addr_extra", {12'b0, req_addr}, 32'hFFFFFFFF);
                    else check_val("addr", {12'b0, req_addr}, exp_q.pop_front());
                    pend      = 1;
                    pend_addr = {12'b0, req_addr};
                end
            end
        end
    end

    task automatic expect_comp(input int idx, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(32'(REG_BASE + idx*16 + 4*k));
    endtask

    task automatic set_comp(input int idx, input logic [31:0] cur, input logic [31:0] old);
        cur_v[idx] = cur;
        old_v[idx] = old;
    endtask

    task automatic set_sw(input int idx, input logic [31:0] cur, input logic [31:0] old);
        sw_versions[64*idx +: 32]    = cur;
        sw_versions[64*idx+32 +: 32] = old;
    endtask

    task automatic check_rb(input string tag, input int idx, input logic [31:0] cur, input logic [31:0] old);
        rd_index = 6'(idx);
        #1;
        check_val({tag, "_cur"}, rd_current, cur);
        check_val({tag, "_old"}, rd_oldest, old);
    endtask

    task automatic check_masks(input string tag, input logic [NC-1:0] inc, input logic [NC-1:0] err);
        check_val({tag, "_incompat"}, 32'(incompat_mask), 32'(inc));
        check_val({tag, "_error"}, 32'(error_mask), 32'(err));
        check_val({tag, "_addr_left"}, 32'(exp_q.size()), 32'h0);
    endtask

    task automatic run_scan(input bit restart, output int done_cnt);
        bit seen;
        seen = 0;
        done_cnt = 0;
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        check_val("busy_after_start", {31'b0, busy}, 32'h1);
        for (int i = 0; i < 2000 && !seen; i++) begin
            start = (restart && i == 3);
            if (done) begin
                seen = 1;
                done_cnt++;
                check_val("busy_at_done", {31'b0, busy}, 32'h0);
            end else begin
                @(negedge clk);
            end
        end
        start = 0;
        if (!seen) check_val("done_timeout", 32'h0, 32'h1);
        repeat (8) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
    endtask

    initial begin
        int dc, s0;
        bit found;
        rst = 1; start = 0; rd_index = 0; sw_versions = '0;
        for (int i = 0; i < NC; i++) begin
            set_comp(i, 32'h00801000, 32'h00801000);
            ts_v[i] = 32'h21061512;
        end
        repeat (3) @(negedge clk);
        check_val("rst_busy", {31'b0, busy}, 32'h0);
        check_val("rst_done", {31'b0, done}, 32'h0);
        check_val("rst_req_rd", {31'b0, req_rd}, 32'h0);
        check_val("rst_addr", {12'b0, req_addr}, 32'h0);
        check_val("rst_state", {29'b0, fsm_state}, 32'h0);
        check_masks("rst", 2'b00, 2'b00);
        check_rb("rst_rb", 0, 32'h0, 32'h0);
        rst = 0;

        // All compatible, equal versions; a second start mid-scan must be ignored
        set_sw(0, 32'h00801000, 32'h00801000);
        set_sw(1, 32'h00801000, 32'h00801000);
        expect_comp(0, NREADS); expect_comp(1, NREADS);
        run_scan(1, dc);
        check_val("t1_done_count", 32'(dc), 32'h1);
        check_masks("t1", 2'b00, 2'b00);
        check_rb("t1_rb0", 0, 32'h00801000, 32'h00801000);
        check_val("t1_ts0", rd_timestamp, EXP_TS);
        check_rb("t1_rb_oob", 2, 32'h0, 32'h0);
        check_val("t1_ts_oob", rd_timestamp, 32'h0);
        check_rb("t1_rb_63", 63, 32'h0, 32'h0);

        // Component 1 too old for SW
        set_comp(1, 32'h00800000, 32'h00800000);
        expect_comp(0, NREADS); expect_comp(1, NREADS);
        run_scan(0, dc);
        check_masks("t2", 2'b10, 2'b00);
        check_rb("t2_rb1", 1, 32'h00800000, 32'h00800000);

        // Component 0 too new for SW
        set_comp(1, 32'h00801000, 32'h00801000);
        set_comp(0, 32'h01000000, 32'h01000000);
        set_sw(0, 32'h00FFF000, 32'h00FFF000);
        expect_comp(0, NREADS); expect_comp(1, NREADS);
        run_scan(0, dc);
        check_masks("t3", 2'b01, 2'b00);
        check_rb("t3_rb0", 0, 32'h01000000, 32'h01000000);

        // Error status on comp0's first read: skip rest, clear stale data, no incompat
        err_mode = 1;
        expect_comp(0, 1); expect_comp(1, NREADS);
        run_scan(0, dc);
        err_mode = 0;
        check_masks("t5", 2'b00, 2'b01);
        check_rb("t5_rb0", 0, 32'h0, 32'h0);

        // No ack for comp0: timeout, guard (late ack injected there), continue to comp1
        set_comp(0, 32'h00801000, 32'h00801000);
        set_sw(0, 32'h00801000, 32'h00801000);
        noack_mode = 1;
        expect_comp(0, 1); expect_comp(1, NREADS);
        run_scan(0, dc);
        noack_mode = 0;
        check_masks("t4", 2'b00, 2'b01);
        check_val("t4_strobe_gap", 32'(gap_comp1), 32'(TIMEOUT_GAP));
        check_rb("t4_rb0", 0, 32'h0, 32'h0);
        check_rb("t4_rb1", 1, 32'h00801000, 32'h00801000);

        // Async reset in WAIT of idx1 after comp0 was flagged incompatible
        set_comp(0, 32'h01000000, 32'h01000000);
        set_sw(0, 32'h00FFF000, 32'h00FFF000);
        rd_index = 0;
        expect_comp(0, NREADS); expect_comp(1, NREADS);
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        found = 0;
        for (int i = 0; i < 500 && !found; i++) begin
            if (req_rd && req_addr == 20'(REG_BASE + 16)) found = 1;
            else @(negedge clk);
        end
        check_val("t6_reach_idx1", {31'b0, found}, 32'h1);
        @(negedge clk);
        check_val("t6_pre_incompat", 32'(incompat_mask), 32'h1);
        #2 rst = 1;
        #1;
        check_val("t6_busy", {31'b0, busy}, 32'h0);
        check_val("t6_req_rd", {31'b0, req_rd}, 32'h0);
        check_val("t6_state", {29'b0, fsm_state}, 32'h0);
        check_val("t6_incompat", 32'(incompat_mask), 32'h0);
        check_val("t6_rb0", rd_current, 32'h0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 0;
        s0 = n_strobes;
        repeat (10) @(negedge clk);
        check_val("t6_no_strobe", 32'(n_strobes - s0), 32'h0);
        set_comp(0, 32'h00801000, 32'h00801000);
        set_sw(0, 32'h00801000, 32'h00801000);
        expect_comp(0, NREADS); expect_comp(1, NREADS);
        run_scan(0, dc);
        check_val("t6_done_count", 32'(dc), 32'h1);
        check_masks("t6", 2'b00, 2'b00);
        check_rb("t6_rb0_after", 0, 32'h00801000, 32'h00801000);
        check_val("t6_ts0", rd_timestamp, EXP_TS);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
